mac_pe_sys: RTL and testbench

//  Parametrised systolic multiply-accumulate processing element, next generation of the scalar MAC PE.
//  Two-stage pipeline: registered product, then accumulate. Valid-qualified inputs, per-operand signed/unsigned mode,

---
 rtl/mac_pe_sys.sv | 160 ++++++++++++++++
 tb/tb_mac_pe_sys.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_pe_sys.sv
// Systolic multiply-accumulate PE: registered product, then accumulate with drain and overflow flag.
// Optional clamping of the sum on overflow is enabled by defining MAC_PE_SAT_EN.
module mac_pe_sys #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              signed_mode,
    input  logic              clr,
    input  logic              drain,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              fwd_valid,
    output logic [ACC_W-1:0]  acc_out,
    output logic              out_valid,
    output logic              ovf
);

    localparam int PROD_W = 2 * DATA_W;

    logic [PROD_W-1:0] a_ext_s;
    logic [PROD_W-1:0] b_ext_s;
    logic [PROD_W-1:0] prod_s;
    logic [PROD_W-1:0] prod_r;
    logic              p_valid_r;
    logic              p_clr_r;
    logic              p_signed_r;
    logic [ACC_W-1:0]  acc_r;
    logic [ACC_W-1:0]  ext_s;
    logic [ACC_W:0]    sum_full_s;
    logic [ACC_W-1:0]  sum_s;
    logic              ovf_hit_s;
    logic              ovf_next_s;

`ifdef MAC_PE_SAT_EN
    // Clamp value for an overflowing sum; direction follows the sign of the addend.
    function automatic logic [ACC_W-1:0] sat_value(input logic is_signed, input logic neg);
        logic [ACC_W-1:0] val;
        if (is_signed) begin
            val = neg ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            val = {ACC_W{1'b1}};
        end
        return val;
    endfunction
`endif

    // Widen product to the accumulator; elaboration stops if the accumulator is too narrow.
    generate
        if (ACC_W < PROD_W) begin : g_bad_acc_w
            $error("mac_pe_sys: ACC_W must be >= 2*DATA_W");
        end else if (ACC_W == PROD_W) begin : g_ext_none
            assign ext_s = prod_r;
        end else begin : g_ext_wide
            assign ext_s = p_signed_r ? {{(ACC_W-PROD_W){prod_r[PROD_W-1]}}, prod_r}
                                      : {{(ACC_W-PROD_W){1'b0}}, prod_r};
        end
    endgenerate

    // Single multiplier: the low 2*DATA_W bits of the extended product are right for both modes.
    always_comb begin
        a_ext_s = signed_mode ? {{DATA_W{a_in[DATA_W-1]}}, a_in} : {{DATA_W{1'b0}}, a_in};
        b_ext_s = signed_mode ? {{DATA_W{b_in[DATA_W-1]}}, b_in} : {{DATA_W{1'b0}}, b_in};
        prod_s  = a_ext_s * b_ext_s;
    end

    // Stage-2 sum, overflow detection and optional clamping.
    always_comb begin
        sum_full_s = {1'b0, acc_r} + {1'b0, ext_s};
        sum_s      = acc_r;
        ovf_hit_s  = 1'b0;
        ovf_next_s = ovf;
        if (p_valid_r) begin
            if (p_clr_r) begin
                sum_s      = ext_s;
                ovf_hit_s  = 1'b0;
                ovf_next_s = 1'b0;
            end else begin
                if (p_signed_r) begin
                    ovf_hit_s = (acc_r[ACC_W-1] == ext_s[ACC_W-1]) &&
                                (sum_full_s[ACC_W-1] != acc_r[ACC_W-1]);
                end else begin
                    ovf_hit_s = sum_full_s[ACC_W];
                end
                sum_s = sum_full_s[ACC_W-1:0];
`ifdef MAC_PE_SAT_EN
                if (ovf_hit_s) begin
                    sum_s = sat_value(p_signed_r, ext_s[ACC_W-1]);
                end else begin
                    sum_s = sum_full_s[ACC_W-1:0];
                end
`endif
                ovf_next_s = ovf | ovf_hit_s;
            end
        end else begin
            sum_s      = acc_r;
            ovf_next_s = ovf;
        end
    end

    // Systolic forwarding of operands to neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out     <= {DATA_W{1'b0}};
            b_out     <= {DATA_W{1'b0}};
            fwd_valid <= 1'b0;
        end else begin
            a_out     <= a_in;
            b_out     <= b_in;
            fwd_valid <= in_valid;
        end
    end

    // Stage-1 product register; product and tags hold when no operands arrive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r     <= {PROD_W{1'b0}};
            p_valid_r  <= 1'b0;
            p_clr_r    <= 1'b0;
            p_signed_r <= 1'b0;
        end else begin
            p_valid_r <= in_valid;
            if (in_valid) begin
                prod_r     <= prod_s;
                p_clr_r    <= clr;
                p_signed_r <= signed_mode;
            end else begin
                prod_r     <= prod_r;
                p_clr_r    <= p_clr_r;
                p_signed_r <= p_signed_r;
            end
        end
    end

    // Accumulator, drain output and sticky overflow; a drain captures this cycle's sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r     <= {ACC_W{1'b0}};
            acc_out   <= {ACC_W{1'b0}};
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= drain;
            if (drain) begin
                acc_out <= sum_s;
                acc_r   <= {ACC_W{1'b0}};
                ovf     <= 1'b0;
            end else begin
                acc_out <= acc_out;
                acc_r   <= sum_s;
                ovf     <= ovf_next_s;
            end
        end
    end

endmodule

// File: tb/tb_mac_pe_sys.sv
// Scoreboard bench for mac_pe_sys: two instances (ACC_W 40 and 32) share one stimulus stream
// and are compared against an integer-arithmetic reference model.
module tb_mac_pe_sys;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, signed_mode, clr, drain;
    logic [15:0] a_in, b_in;

    logic [15:0] a_out40, b_out40, a_out32, b_out32;
    logic        fwd40, fwd32, ov40, ov32, ovf40, ovf32;
    logic [39:0] acc40;
    logic [31:0] acc32;

    int checks   = 0;
    int failures = 0;

    // reference model state (index 0: 40-bit, index 1: 32-bit)
    longint      m_acc [2];
    bit          m_ovf [2];
    bit          e_ov  [2];
    bit          p_v, p_clr, p_sgn;
    longint      p_prod;
    logic [15:0] e_a, e_b;
    bit          e_fv;
    longint      q40[$];
    longint      q32[$];

    always #5 clk = ~clk;

    mac_pe_sys #(.DATA_W(16), .ACC_W(40)) u_dut40 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a_in(a_in), .b_in(b_in),
        .signed_mode(signed_mode), .clr(clr), .drain(drain),
        .a_out(a_out40), .b_out(b_out40), .fwd_valid(fwd40),
        .acc_out(acc40), .out_valid(ov40), .ovf(ovf40)
    );

    mac_pe_sys #(.DATA_W(16), .ACC_W(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a_in(a_in), .b_in(b_in),
        .signed_mode(signed_mode), .clr(clr), .drain(drain),
        .a_out(a_out32), .b_out(b_out32), .fwd_valid(fwd32),
        .acc_out(acc32), .out_valid(ov32), .ovf(ovf32)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = 0;
            m_ovf[k] = 1'b0;
            e_ov[k]  = 1'b0;
        end
        p_v = 1'b0; p_clr = 1'b0; p_sgn = 1'b0; p_prod = 0;
        e_a = 16'd0; e_b = 16'd0; e_fv = 1'b0;
        q40.delete();
        q32.delete();
    endtask

    // What each PE holds after the coming clock edge, from arithmetic on integer values.
    task automatic model_step(input bit iv, input logic [15:0] a, input logic [15:0] b,
                              input bit sm, input bit cl, input bit dr);
        for (int k = 0; k < 2; k++) begin
            int     w;
            longint mask, hi, lo, base, total, sum;
            bit     o, novf;
            w    = (k == 0) ? 40 : 32;
            mask = (longint'(1) << w) - 1;
            sum  = m_acc[k];
            novf = m_ovf[k];
            if (p_v) begin
                if (p_sgn) begin
                    hi    = (longint'(1) << (w - 1)) - 1;
                    lo    = -(longint'(1) << (w - 1));
                    base  = (m_acc[k] > hi) ? m_acc[k] - (mask + 1) : m_acc[k];
                    if (p_clr) base = 0;
                    total = base + p_prod;
                    o     = (total > hi) || (total < lo);
`ifdef MAC_PE_SAT_EN
                    if (o) total = (total > hi) ? hi : lo;
`endif
                end else begin
                    base  = p_clr ? 0 : m_acc[k];
                    total = base + p_prod;
                    o     = total > mask;
`ifdef MAC_PE_SAT_EN
                    if (o) total = mask;
`endif
                end
                sum  = total & mask;
                novf = p_clr ? o : (m_ovf[k] | o);
            end
            e_ov[k] = dr;
            if (dr) begin
                if (k == 0) q40.push_back(sum);
                else        q32.push_back(sum);
                m_acc[k] = 0;
                m_ovf[k] = 1'b0;
            end else begin
                m_acc[k] = sum;
                m_ovf[k] = novf;
            end
        end
        p_v = iv;
        if (iv) begin
            p_sgn  = sm;
            p_clr  = cl;
            p_prod = sm ? longint'($signed(a)) * longint'($signed(b)) : longint'(a) * longint'(b);
        end
        e_a = a; e_b = b; e_fv = iv;
    endtask

    task automatic cycle(input bit iv, input logic [15:0] a, input logic [15:0] b,
                         input bit sm, input bit cl, input bit dr);
        @(negedge clk);
        in_valid = iv; a_in = a; b_in = b; signed_mode = sm; clr = cl; drain = dr;
        model_step(iv, a, b, sm, cl, dr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_a_out"}, {a_out40, a_out32}, 64'd0);
        chk({tag, "_b_out"}, {b_out40, b_out32}, 64'd0);
        chk({tag, "_fwd_valid"}, {fwd40, fwd32}, 64'd0);
        chk({tag, "_acc_out40"}, acc40, 64'd0);
        chk({tag, "_acc_out32"}, acc32, 64'd0);
        chk({tag, "_out_valid"}, {ov40, ov32}, 64'd0);
        chk({tag, "_ovf"}, {ovf40, ovf32}, 64'd0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0; drain = 1'b0; clr = 1'b0;
        model_reset();
        #1;
        check_all_zero("reset_mid");
        @(negedge clk);
        rst_n = 1'b1;
        a_in = 16'd0; b_in = 16'd0; signed_mode = 1'b0;
        model_step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compares every cycle just after the active edge, pops the scoreboard on out_valid.
    initial begin
        forever begin
            longint e;
            @(posedge clk);
            #1;
            chk("a_out40", a_out40, e_a);
            chk("b_out40", b_out40, e_b);
            chk("fwd_valid40", fwd40, e_fv);
            chk("a_out32", a_out32, e_a);
            chk("b_out32", b_out32, e_b);
            chk("fwd_valid32", fwd32, e_fv);
            chk("out_valid40", ov40, e_ov[0]);
            chk("out_valid32", ov32, e_ov[1]);
            chk("ovf40", ovf40, m_ovf[0]);
            chk("ovf32", ovf32, m_ovf[1]);
            if (ov40 === 1'b1) begin
                if (q40.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL acc_out40_unexpected actual=0x%0h required=no_output", acc40);
                end else begin
                    e = q40.pop_front();
                    chk("acc_out40", acc40, e);
                end
            end
            if (ov32 === 1'b1) begin
                if (q32.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL acc_out32_unexpected actual=0x%0h required=no_output", acc32);
                end else begin
                    e = q32.pop_front();
                    chk("acc_out32", acc32, e);
                end
            end
        end
    end

    initial begin
        logic [31:0] sat32;
        rst_n = 1'b0;
        in_valid = 1'b0; a_in = 16'd0; b_in = 16'd0;
        signed_mode = 1'b0; clr = 1'b0; drain = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset_state");
        rst_n = 1'b1;
        model_step(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);

        // drain right after reset emits zero
        cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("drain_after_reset", acc40, 64'd0);

        // basic two-product sum
        cycle(1'b1, 16'd10, 16'd20, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 16'd30, 16'd40, 1'b0, 1'b0, 1'b0);
        idle(1);
        cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        chk("basic_ovf", ovf40, 64'd0);
        idle(1);
        chk("basic_acc", acc40, 64'd1400);

        // signed and unsigned interpretation of the same bits
        cycle(1'b1, 16'hFFFD, 16'd5, 1'b1, 1'b1, 1'b0);
        idle(1);
        cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("signed_acc40", acc40, 64'hFF_FFFF_FFF1);
        chk("signed_acc32", acc32, 64'hFFFF_FFF1);
        cycle(1'b1, 16'hFFFD, 16'd5, 1'b0, 1'b1, 1'b0);
        idle(1);
        cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("unsigned_acc40", acc40, 64'h4_FFF1);

        // unsigned overflow on the 32-bit accumulator
        cycle(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        idle(1);
        cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        chk("ovf32_set", ovf32, 64'd1);
        chk("ovf40_clear", ovf40, 64'd0);
        idle(1);
`ifdef MAC_PE_SAT_EN
        sat32 = 32'hFFFF_FFFF;
`else
        sat32 = 32'hFFFC_0002;
`endif
        chk("ovf_acc32", acc32, sat32);
        chk("ovf_acc40", acc40, 64'h1_FFFC_0002);
        chk("ovf32_after_drain", ovf32, 64'd0);

        // drain on the edge a product retires, then a fresh sum from zero
        cycle(1'b1, 16'd10, 16'd10, 1'b0, 1'b1, 1'b0);
        idle(1);
        cycle(1'b1, 16'd7, 16'd6, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("collision_acc", acc40, 64'd142);
        cycle(1'b1, 16'd2, 16'd3, 1'b0, 1'b0, 1'b0);
        idle(1);
        cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("after_collision_acc", acc40, 64'd6);

        // back-to-back drains
        cycle(1'b1, 16'd7, 16'd7, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        chk("b2b_first", acc40, 64'd49);
        idle(1);
        chk("b2b_second", acc40, 64'd0);

        // reset while products are in flight
        cycle(1'b1, 16'd9, 16'd9, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 16'd3, 16'd3, 1'b0, 1'b0, 1'b0);
        reset_pulse();
        cycle(1'b1, 16'd4, 16'd5, 1'b0, 1'b1, 1'b0);
        idle(1);
        cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1);
        idle(1);
        chk("post_reset_acc", acc40, 64'd20);

        // randomized traffic, with one reset in the middle
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] ra, rb;
            ra = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
            if (i == 1500) reset_pulse();
            cycle($urandom_range(0, 3) != 0, ra, rb, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0);
        end
        idle(4);
        chk("q40_drained", q40.size(), 64'd0);
        chk("q32_drained", q32.size(), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
